// File: rtl/rfile_pkg.sv
// Shared types and helpers for the rfile_mp integer register file.
// Optional build macro used by rfile_mp: RFILE_BYPASS_EN.
package rfile_pkg;

    // Widest register the lane helper supports; callers truncate to XLEN.
    localparam int unsigned LM_W = 512;

    localparam int unsigned SZ_B = 0;
    localparam int unsigned SZ_H = 1;
    localparam int unsigned SZ_W = 2;
    localparam int unsigned SZ_D = 3;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef struct packed {
        logic [LM_W-1:0] mask;
        logic [LM_W-1:0] data;
    } lane_t;

    // Bit mask and aligned data for one sub-word write; oversize codes mean full width.
    function automatic lane_t lane_mask(input int unsigned size, input int unsigned pos,
                                        input int unsigned xlen, input logic [LM_W-1:0] data);
        lane_t           res;
        int unsigned     w;
        int unsigned     off;
        logic [LM_W-1:0] low;
        w = (size >= 16) ? xlen : (32'd8 << size);
        if (w > xlen) w = xlen;
        // Both w and xlen are powers of two, so this equals (pos mod xlen/w) * w.
        off      = (pos * w) & (xlen - 32'd1);
        low      = {LM_W{1'b1}} >> (LM_W - w);
        res.mask = low << off;
        res.data = (data & low) << off;
        return res;
    endfunction

endpackage

// File: rtl/rfile_mp_if.sv
// Read/write port bundle between issue/writeback and the rfile_mp register file.
interface rfile_mp_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned XN   = 64,
    parameter int unsigned NRD  = 3,
    parameter int unsigned NWR  = 2
);
    localparam int unsigned XWDT = $clog2(XN);
    localparam int unsigned SZW  = $clog2($clog2(XLEN/8) + 1);
    localparam int unsigned PSW  = ($clog2(XLEN/8) < 1) ? 1 : $clog2(XLEN/8);

    logic                           ready;
    logic [NWR-1:0]                 we;
    logic [NWR-1:0][XWDT-1:0]       waddr;
    logic [NWR-1:0][XLEN-1:0]       wdata;
    logic [NWR-1:0][SZW-1:0]        wsize;
    logic [NWR-1:0][PSW-1:0]        wpos;
    logic [NRD-1:0][XWDT-1:0]       raddr;
    logic [NRD-1:0][XLEN-1:0]       rdata;

    modport master (output we, waddr, wdata, wsize, wpos, raddr,
                    input  ready, rdata);
    modport slave  (input  we, waddr, wdata, wsize, wpos, raddr,
                    output ready, rdata);
endinterface

// File: rtl/rfile_wmerge.sv
// Merges all write ports into the next value and touched-bit mask of one register.
module rfile_wmerge
    import rfile_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned XWDT     = 6,
    parameter int unsigned NWR      = 2,
    parameter int unsigned SZW      = 2,
    parameter int unsigned PSW      = 3,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [XWDT-1:0]           i_idx,
    input  logic [XLEN-1:0]           i_cur,
    input  logic                      i_en,
    input  logic [NWR-1:0]            i_we,
    input  logic [NWR-1:0][XWDT-1:0]  i_waddr,
    input  logic [NWR-1:0][XLEN-1:0]  i_wdata,
    input  logic [NWR-1:0][SZW-1:0]   i_wsize,
    input  logic [NWR-1:0][PSW-1:0]   i_wpos,
    output logic [XLEN-1:0]           o_next_c,
    output logic [XLEN-1:0]           o_mask_c
);
    lane_t w_lane;
    logic  w_drop;

    assign w_drop = (ZERO_REG != 0) && (i_idx == '0);

    // Ascending port order: later ports overwrite earlier ones on shared bytes.
    always_comb begin
        o_next_c = i_cur;
        o_mask_c = '0;
        w_lane   = '0;
        for (int i = 0; i < int'(NWR); i++) begin
            if (i_en && i_we[i] && (i_waddr[i] == i_idx) && !w_drop) begin
                w_lane   = lane_mask(32'(i_wsize[i]), 32'(i_wpos[i]), XLEN, LM_W'(i_wdata[i]));
                o_next_c = (o_next_c & ~XLEN'(w_lane.mask)) | XLEN'(w_lane.data);
                o_mask_c = o_mask_c | XLEN'(w_lane.mask);
            end
        end
    end

endmodule

// File: rtl/rfile_mp.sv
// Multi-port integer register file with byte-lane writes and a power-on clear sweep.
// Build macro RFILE_BYPASS_EN forwards same-cycle writes into the read ports.
module rfile_mp
    import rfile_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned XN       = 64,
    parameter int unsigned XWDT     = $clog2(XN),
    parameter int unsigned NRD      = 3,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    rfile_mp_if.slave  bus
);
    localparam int unsigned SZW = $clog2($clog2(XLEN/8) + 1);
    localparam int unsigned PSW = ($clog2(XLEN/8) < 1) ? 1 : $clog2(XLEN/8);

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic [XWDT-1:0]           r_cnt;
    logic                      r_ready;
    logic [XLEN-1:0]           r_regs [XN];
    logic [NRD-1:0][XLEN-1:0]  r_rdata;
    logic [XLEN-1:0]           w_next [XN];
    logic [XLEN-1:0]           w_mask [XN];
    logic [NRD-1:0][XLEN-1:0]  w_rd_c;
    logic                      w_run;

    assign w_run     = (r_state == RUN);
    assign bus.ready = r_ready;
    assign bus.rdata = r_rdata;

    // Clear sweep ends after the last index; RUN holds until reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR:   if (r_cnt == XWDT'(XN - 1)) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == RUN);
            if (r_state == CLEAR) r_cnt <= r_cnt + XWDT'(1);
        end
    end

    for (genvar k = 0; k < int'(XN); k++) begin : g_reg
        rfile_wmerge #(
            .XLEN(XLEN), .XWDT(XWDT), .NWR(NWR), .SZW(SZW), .PSW(PSW), .ZERO_REG(ZERO_REG)
        ) u_wm (
            .i_idx   (XWDT'(k)),
            .i_cur   (r_regs[k]),
            .i_en    (w_run),
            .i_we    (bus.we),
            .i_waddr (bus.waddr),
            .i_wdata (bus.wdata),
            .i_wsize (bus.wsize),
            .i_wpos  (bus.wpos),
            .o_next_c(w_next[k]),
            .o_mask_c(w_mask[k])
        );
    end

    // Storage has no reset of its own; the sweep zeroes it one index per cycle.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(XN); k++) begin
            if (rst_n) begin
                if (r_state == CLEAR) begin
                    if (r_cnt == XWDT'(k)) r_regs[k] <= '0;
                end else if (|w_mask[k]) begin
                    r_regs[k] <= w_next[k];
                end
            end
        end
    end

`ifdef RFILE_BYPASS_EN
    logic [NRD-1:0][XLEN-1:0] w_byp_next;
    logic [NRD-1:0][XLEN-1:0] w_byp_mask;

    for (genvar j = 0; j < int'(NRD); j++) begin : g_byp
        rfile_wmerge #(
            .XLEN(XLEN), .XWDT(XWDT), .NWR(NWR), .SZW(SZW), .PSW(PSW), .ZERO_REG(ZERO_REG)
        ) u_byp (
            .i_idx   (bus.raddr[j]),
            .i_cur   (r_regs[bus.raddr[j]]),
            .i_en    (w_run),
            .i_we    (bus.we),
            .i_waddr (bus.waddr),
            .i_wdata (bus.wdata),
            .i_wsize (bus.wsize),
            .i_wpos  (bus.wpos),
            .o_next_c(w_byp_next[j]),
            .o_mask_c(w_byp_mask[j])
        );
    end

    always_comb begin
        w_rd_c = '0;
        for (int j = 0; j < int'(NRD); j++) begin
            w_rd_c[j] = (|w_byp_mask[j]) ? w_byp_next[j] : r_regs[bus.raddr[j]];
        end
    end
`else
    always_comb begin
        w_rd_c = '0;
        for (int j = 0; j < int'(NRD); j++) begin
            w_rd_c[j] = r_regs[bus.raddr[j]];
        end
    end
`endif

    // Read data stays zero through reset and the sweep.
    always_ff @(posedge clk) begin
        for (int j = 0; j < int'(NRD); j++) begin
            if (!rst_n || (r_state == CLEAR)) begin
                r_rdata[j] <= '0;
            end else if ((ZERO_REG != 0) && (bus.raddr[j] == '0)) begin
                r_rdata[j] <= '0;
            end else begin
                r_rdata[j] <= w_rd_c[j];
            end
        end
    end

endmodule

// File: tb/tb_rfile_mp.sv
// Scoreboard bench for rfile_mp: one instance with ZERO_REG=1 and one with ZERO_REG=0.
module tb_rfile_mp;

    logic clk;
    logic rst_n;

    logic [1:0]       tb_we;
    logic [1:0][5:0]  tb_waddr;
    logic [1:0][63:0] tb_wdata;
    logic [1:0][1:0]  tb_wsize;
    logic [1:0][2:0]  tb_wpos;
    logic [2:0][5:0]  tb_raddr;

    rfile_mp_if #(.XLEN(64), .XN(64), .NRD(3), .NWR(2)) if_z ();
    rfile_mp_if #(.XLEN(64), .XN(64), .NRD(3), .NWR(2)) if_n ();

    assign if_z.we = tb_we;  assign if_z.waddr = tb_waddr;  assign if_z.wdata = tb_wdata;
    assign if_z.wsize = tb_wsize;  assign if_z.wpos = tb_wpos;  assign if_z.raddr = tb_raddr;
    assign if_n.we = tb_we;  assign if_n.waddr = tb_waddr;  assign if_n.wdata = tb_wdata;
    assign if_n.wsize = tb_wsize;  assign if_n.wpos = tb_wpos;  assign if_n.raddr = tb_raddr;

    rfile_mp #(.XLEN(64), .XN(64), .NRD(3), .NWR(2), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .bus(if_z));
    rfile_mp #(.XLEN(64), .XN(64), .NRD(3), .NWR(2), .ZERO_REG(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .bus(if_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] mz [64];
    logic [63:0] mn [64];
    bit          run;
    int          cnt;
    logic [63:0] exp_q [$];
    string       tag_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-lane reference merge of the currently driven write ports into one register.
    function automatic logic [63:0] merged(input logic [63:0] cur, input int a, input bit zr);
        logic [63:0] v;
        int          nb;
        int          slot;
        v = cur;
        if (zr && a == 0) return cur;
        for (int i = 0; i < 2; i++) begin
            if (tb_we[i] && int'(tb_waddr[i]) == a) begin
                nb = 1 << int'(tb_wsize[i]);
                if (nb > 8) nb = 8;
                slot = int'(tb_wpos[i]) % (8 / nb);
                for (int b = 0; b < nb; b++) v[(slot*nb + b)*8 +: 8] = tb_wdata[i][b*8 +: 8];
            end
        end
        return v;
    endfunction

    task automatic step();
        logic [63:0] e;
        int          a;
        for (int j = 0; j < 3; j++) begin
            a = int'(tb_raddr[j]);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n || !run || (d == 0 && a == 0)) e = '0;
                else begin
`ifdef RFILE_BYPASS_EN
                    e = (d == 0) ? merged(mz[a], a, 1'b1) : merged(mn[a], a, 1'b0);
`else
                    e = (d == 0) ? mz[a] : mn[a];
`endif
                end
                exp_q.push_back(e);
                tag_q.push_back((d == 0) ? "rd_z" : "rd_n");
            end
        end
        if (!rst_n) begin
            run = 0;
            cnt = 0;
        end else if (!run) begin
            mz[cnt] = '0;
            mn[cnt] = '0;
            cnt++;
            if (cnt == 64) run = 1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (tb_we[i]) begin
                    a = int'(tb_waddr[i]);
                    mz[a] = merged(mz[a], a, 1'b1);
                    mn[a] = merged(mn[a], a, 1'b0);
                end
            end
        end
        exp_q.push_back(64'(run));
        tag_q.push_back("ready");
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            chk(tag_q.pop_front(), if_z.rdata[j], exp_q.pop_front());
            chk(tag_q.pop_front(), if_n.rdata[j], exp_q.pop_front());
        end
        chk(tag_q.pop_front(), 64'(if_z.ready), exp_q.pop_front());
        total++;
        if (if_n.ready !== if_z.ready) begin
            bad++;
            $display("FAIL ready_n got=%b exp=%b", if_n.ready, if_z.ready);
        end
    endtask

    task automatic wr(input int p, input int addr, input logic [63:0] data,
                      input int size, input int pos);
        tb_we[p]    = 1'b1;
        tb_waddr[p] = 6'(addr);
        tb_wdata[p] = data;
        tb_wsize[p] = 2'(size);
        tb_wpos[p]  = 3'(pos);
    endtask

    task automatic idle();
        tb_we = '0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) begin
            mz[i] = '0;
            mn[i] = '0;
        end
        run = 0; cnt = 0;
        rst_n = 1'b0;
        tb_we = '0; tb_waddr = '0; tb_wdata = '0; tb_wsize = '0; tb_wpos = '0;
        tb_raddr = {6'd63, 6'd1, 6'd2};
        @(negedge clk);
        step(); step();

        // Sweep with a stray write to r2 that must be dropped, restarted mid-way.
        rst_n = 1'b1;
        wr(0, 2, 64'h99, 3, 0);
        repeat (30) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!if_z.ready && n < 200);
        chk("sweep_len", 64'(n), 64'd64);
        idle();
        step();
        chk("r2_after_clear", if_z.rdata[0], 64'h0);
        chk("r63_after_clear", if_z.rdata[2], 64'h0);

        // Sub-word writes into r5.
        tb_raddr = {6'd5, 6'd5, 6'd5};
        wr(0, 5, 64'hAB, 0, 3);
        step();
        idle();
        step();
        chk("r5_byte", if_z.rdata[0], 64'h00000000AB000000);
        wr(1, 5, 64'h1234, 1, 3);
        step();
        idle();
        step();
        chk("r5_half", if_z.rdata[1], 64'h12340000AB000000);

        // Two ports to r7 in one cycle.
        tb_raddr = {6'd7, 6'd0, 6'd7};
        wr(0, 7, 64'h1111111111111111, 3, 0);
        wr(1, 7, 64'hDEADBEEF, 2, 1);
        step();
        idle();
        step();
        chk("r7_merge", if_z.rdata[0], 64'hDEADBEEF11111111);
        wr(0, 7, 64'h1111111111111111, 3, 0);
        wr(1, 7, 64'h2, 3, 0);
        step();
        idle();
        step();
        chk("r7_prio", if_z.rdata[2], 64'h2);

        // Register 0 behaviour in both builds.
        tb_raddr = {6'd0, 6'd0, 6'd0};
        wr(0, 0, 64'hFFFF, 3, 0);
        step();
        idle();
        step();
        chk("r0_zero", if_z.rdata[0], 64'h0);
        chk("r0_plain", if_n.rdata[0], 64'hFFFF);

        // Read and write of r9 in the same cycle.
        tb_raddr = {6'd9, 6'd9, 6'd9};
        wr(0, 9, 64'h5, 3, 0);
        step();
        wr(1, 9, 64'h77, 3, 0);
        step();
`ifdef RFILE_BYPASS_EN
        chk("r9_raw", if_z.rdata[0], 64'h77);
`else
        chk("r9_raw", if_z.rdata[0], 64'h5);
`endif
        idle();
        step();
        chk("r9_next", if_z.rdata[0], 64'h77);

        // Random traffic on a small index set to force collisions.
        for (int t = 0; t < 120; t++) begin
            for (int p = 0; p < 2; p++) begin
                tb_we[p]    = 1'($urandom_range(0, 1));
                tb_waddr[p] = 6'($urandom_range(0, 7));
                tb_wdata[p] = {$urandom, $urandom};
                tb_wsize[p] = 2'($urandom_range(0, 3));
                tb_wpos[p]  = 3'($urandom_range(0, 7));
            end
            for (int j = 0; j < 3; j++) tb_raddr[j] = 6'($urandom_range(0, 7));
            step();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
